// File: rtl/uart_rx_ctrl.sv
// Configuration, FWFT receive FIFO and error statistics beside the UART receiver.
// Optional UART_RX_ERR_DROP_EN: frames with parity/stop errors are counted but not stored.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          cfg_wr,
    input  logic [5:0]                    cfg_prescale,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_typ,
    output logic                          cfg_err,
    output logic                          cfg_pend,
    output logic [5:0]                    prescale,
    output logic                          PAR_EN,
    output logic                          PAR_TYP,
    input  logic                          rx_busy,
    input  logic                          data_valid,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          par_err,
    input  logic                          stp_err,
    input  logic                          strt_glitch,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_par_err,
    output logic                          rd_stp_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overrun,
    output logic [CNT_WIDTH-1:0]          par_err_cnt,
    output logic [CNT_WIDTH-1:0]          stp_err_cnt,
    output logic [CNT_WIDTH-1:0]          glitch_cnt,
    input  logic                          stat_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {RUN, PEND, APPLY} cfg_state_t;

    cfg_state_t state, nxt;
    logic       cfg_legal, cfg_take, load_shadow, apply_en;
    logic [5:0] sh_prescale;
    logic       sh_par_en, sh_par_typ;

    assign cfg_legal = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
    // Requests arriving during APPLY are dropped silently.
    assign cfg_take  = cfg_wr && (state != APPLY);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= RUN;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            RUN:     if (cfg_wr && cfg_legal) nxt = PEND;
            PEND:    if (!rx_busy) nxt = APPLY;
            APPLY:   nxt = RUN;
            default: nxt = RUN;
        endcase
    end

    always_comb begin
        cfg_pend    = (state == PEND);
        load_shadow = cfg_take && cfg_legal;
        apply_en    = (state == APPLY);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_prescale <= 6'd8;
            sh_par_en   <= 1'b0;
            sh_par_typ  <= 1'b0;
            prescale    <= 6'd8;
            PAR_EN      <= 1'b0;
            PAR_TYP     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= cfg_take && !cfg_legal;
            if (load_shadow) begin
                sh_prescale <= cfg_prescale;
                sh_par_en   <= cfg_par_en;
                sh_par_typ  <= cfg_par_typ;
            end
            if (apply_en) begin
                prescale <= sh_prescale;
                PAR_EN   <= sh_par_en;
                PAR_TYP  <= sh_par_typ;
            end
        end
    end

    // FIFO: extra pointer bit distinguishes full from empty.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr;
    logic [EW-1:0] head;
    logic          wr_req, full, do_rd, do_wr;

`ifdef UART_RX_ERR_DROP_EN
    assign wr_req = data_valid && !par_err && !stp_err;
`else
    assign wr_req = data_valid;
`endif

    assign fifo_cnt = wptr - rptr;
    assign full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign rd_valid = (fifo_cnt != '0);
    assign do_rd    = rd_en && rd_valid;
    assign do_wr    = wr_req && (!full || do_rd);
    assign head     = mem[rptr[AW-1:0]];
    assign rd_data  = rd_valid ? head[DATA_WIDTH-1:0] : '0;
`ifdef UART_RX_ERR_DROP_EN
    assign rd_par_err = 1'b0;
    assign rd_stp_err = 1'b0;
`else
    assign rd_par_err = rd_valid && head[EW-1];
    assign rd_stp_err = rd_valid && head[EW-2];
`endif

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wptr[AW-1:0]] <= {par_err, stp_err, P_DATA};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + (AW+1)'(1);
            if (do_rd) rptr <= rptr + (AW+1)'(1);
        end
    end

    logic glitch_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            glitch_d    <= 1'b0;
            overrun     <= 1'b0;
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
            glitch_cnt  <= '0;
        end else begin
            glitch_d <= strt_glitch;
            if (stat_clr) begin
                overrun     <= 1'b0;
                par_err_cnt <= '0;
                stp_err_cnt <= '0;
                glitch_cnt  <= '0;
            end else begin
                if (wr_req && full && !do_rd) overrun <= 1'b1;
                if (data_valid && par_err && par_err_cnt != CNT_MAX)
                    par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
                if (data_valid && stp_err && stp_err_cnt != CNT_MAX)
                    stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
                if (strt_glitch && !glitch_d && glitch_cnt != CNT_MAX)
                    glitch_cnt <= glitch_cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed config checks plus a queue-based FIFO/statistics scoreboard.
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0, RST = 1'b0;
    logic          cfg_wr = 0, cfg_par_en = 0, cfg_par_typ = 0;
    logic [5:0]    cfg_prescale = 6'd8;
    logic          cfg_err, cfg_pend, PAR_EN, PAR_TYP;
    logic [5:0]    prescale;
    logic          rx_busy = 0, data_valid = 0, par_err = 0, stp_err = 0, strt_glitch = 0;
    logic [DW-1:0] P_DATA = '0;
    logic          rd_en = 0, stat_clr = 0;
    logic          rd_valid, rd_par_err, rd_stp_err, overrun;
    logic [DW-1:0] rd_data;
    logic [2:0]    fifo_cnt;
    logic [7:0]    par_err_cnt, stp_err_cnt, glitch_cnt;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale),
        .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .cfg_err(cfg_err),
        .cfg_pend(cfg_pend), .prescale(prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .rx_busy(rx_busy), .data_valid(data_valid), .P_DATA(P_DATA), .par_err(par_err),
        .stp_err(stp_err), .strt_glitch(strt_glitch), .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_stp_err(rd_stp_err),
        .fifo_cnt(fifo_cnt), .overrun(overrun), .par_err_cnt(par_err_cnt),
        .stp_err_cnt(stp_err_cnt), .glitch_cnt(glitch_cnt), .stat_clr(stat_clr)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;
    bit mon_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: a bounded queue of {par,stp,data} plus saturating integer counters.
    logic [DW+1:0] q[$];
    int  m_par = 0, m_stp = 0, m_gl = 0;
    bit  m_ovr = 0, m_gprev = 0, m_store = 0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q.delete();
            m_par = 0; m_stp = 0; m_gl = 0; m_ovr = 0; m_gprev = 0;
        end else begin
            if (rd_en && q.size() > 0) void'(q.pop_front());
            m_store = data_valid;
`ifdef UART_RX_ERR_DROP_EN
            if (par_err || stp_err) m_store = 0;
`endif
            if (m_store) begin
                if (q.size() < DEPTH) q.push_back({par_err, stp_err, P_DATA});
                else m_ovr = 1;
            end
            if (data_valid && par_err && m_par < 255) m_par++;
            if (data_valid && stp_err && m_stp < 255) m_stp++;
            if (strt_glitch && !m_gprev && m_gl < 255) m_gl++;
            m_gprev = strt_glitch;
            if (stat_clr) begin
                m_par = 0; m_stp = 0; m_gl = 0; m_ovr = 0;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the model, mid-cycle.
    always @(negedge CLK) begin
        if (mon_en && RST) begin
            chk("mon_rd_valid", 32'(rd_valid), 32'(q.size() != 0));
            chk("mon_fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
            chk("mon_overrun", 32'(overrun), 32'(m_ovr));
            chk("mon_par_cnt", 32'(par_err_cnt), 32'(m_par));
            chk("mon_stp_cnt", 32'(stp_err_cnt), 32'(m_stp));
            chk("mon_gl_cnt", 32'(glitch_cnt), 32'(m_gl));
            if (q.size() > 0)
                chk("mon_head", 32'({rd_par_err, rd_stp_err, rd_data}), 32'(q[0]));
        end
    end

    task automatic cfg_req(input logic [5:0] p, input logic en, input logic typ);
        cfg_wr = 1; cfg_prescale = p; cfg_par_en = en; cfg_par_typ = typ;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step(); step();
        RST = 1;
        step();
        chk("rst_prescale", 32'(prescale), 8);
        chk("rst_par_en", 32'(PAR_EN), 0);
        chk("rst_par_typ", 32'(PAR_TYP), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
        chk("rst_counters", 32'({par_err_cnt, stp_err_cnt, glitch_cnt}), 0);
        chk("rst_flags", 32'({overrun, cfg_err, cfg_pend}), 0);
        mon_en = 1;

        // Config held off while a frame is in progress.
        rx_busy = 1; cfg_req(6'd16, 1, 1);
        step(); cfg_wr = 0;
        for (int i = 0; i < 20; i++) begin
            chk("busy_pend", 32'(cfg_pend), 1);
            chk("busy_cfg", 32'({prescale, PAR_EN, PAR_TYP}), 32'({6'd8, 2'b00}));
            step();
        end
        rx_busy = 0;
        step();
        chk("apply_pend", 32'(cfg_pend), 0);
        chk("apply_old", 32'(prescale), 8);
        step();
        chk("apply_new", 32'({prescale, PAR_EN, PAR_TYP}), 32'({6'd16, 2'b11}));

        // Illegal prescale rejected.
        cfg_req(6'd12, 0, 0);
        step(); cfg_wr = 0;
        chk("ill_err", 32'(cfg_err), 1);
        chk("ill_pend", 32'(cfg_pend), 0);
        chk("ill_prescale", 32'(prescale), 16);
        step();
        chk("ill_err_pulse", 32'(cfg_err), 0);

        // Minimum latency; a request during APPLY is ignored.
        cfg_req(6'd32, 0, 1);
        step(); cfg_wr = 0;
        chk("lat_pend", 32'(cfg_pend), 1);
        step();
        chk("lat_old", 32'(prescale), 16);
        cfg_req(6'd12, 1, 1);
        step(); cfg_wr = 0;
        chk("lat_new", 32'({prescale, PAR_EN, PAR_TYP}), 32'({6'd32, 2'b01}));
        chk("apply_wr_err", 32'(cfg_err), 0);
        chk("apply_wr_pend", 32'(cfg_pend), 0);

        // Last legal request in PEND wins; illegal one keeps the shadow.
        rx_busy = 1; cfg_req(6'd8, 1, 0);
        step(); cfg_req(6'd16, 0, 0);
        step(); cfg_req(6'd12, 1, 1);
        step(); cfg_wr = 0;
        chk("pend_ill_err", 32'(cfg_err), 1);
        chk("pend_still", 32'(cfg_pend), 1);
        rx_busy = 0;
        step(); step();
        chk("pend_last", 32'({prescale, PAR_EN, PAR_TYP}), 32'({6'd16, 2'b00}));

        // Overflow: five frames into four entries.
        for (int i = 0; i < 5; i++) begin
            data_valid = 1; P_DATA = 8'hA1 + 8'(i);
            step();
        end
        data_valid = 0;
        chk("ovf_cnt", 32'(fifo_cnt), 4);
        chk("ovf_flag", 32'(overrun), 1);
        chk("ovf_head", 32'(rd_data), 32'h A1);
        stat_clr = 1; step(); stat_clr = 0;
        chk("clr_ovr", 32'(overrun), 0);
        chk("clr_fifo_kept", 32'(fifo_cnt), 4);
        // Full with simultaneous write and read.
        data_valid = 1; P_DATA = 8'h5A; rd_en = 1;
        step(); data_valid = 0;
        chk("full_rw_cnt", 32'(fifo_cnt), 4);
        chk("full_rw_ovr", 32'(overrun), 0);
        chk("full_rw_head", 32'(rd_data), 32'h A2);
        step(); step(); step(); step(); rd_en = 0;
        chk("drained", 32'(rd_valid), 0);
        // Empty with simultaneous write and read.
        data_valid = 1; P_DATA = 8'h3C; rd_en = 1;
        step(); data_valid = 0;
        chk("empty_rw_cnt", 32'(fifo_cnt), 1);
        chk("empty_rw_data", 32'(rd_data), 32'h3C);
        step(); rd_en = 0;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            data_valid  = ($urandom_range(0, 2) == 0);
            P_DATA      = 8'($urandom);
            par_err     = ($urandom_range(0, 3) == 0);
            stp_err     = ($urandom_range(0, 3) == 0);
            rd_en       = ($urandom_range(0, 2) == 0);
            strt_glitch = $urandom_range(0, 1) == 1;
            stat_clr    = ($urandom_range(0, 60) == 0);
            rx_busy     = $urandom_range(0, 1) == 1;
            step();
        end
        {data_valid, par_err, stp_err, strt_glitch, stat_clr, rx_busy} = '0;
        rd_en = 1; step(); step(); step(); step(); step(); rd_en = 0;
        stat_clr = 1; step(); stat_clr = 0;

        // Parity-error counter saturation.
        for (int i = 0; i < 300; i++) begin
            data_valid = 1; par_err = 1; rd_en = 1; P_DATA = 8'($urandom);
            step();
        end
        data_valid = 0; par_err = 0;
        chk("par_sat", 32'(par_err_cnt), 255);
        step(); rd_en = 0;
`ifdef UART_RX_ERR_DROP_EN
        chk("drop_empty", 32'(rd_valid), 0);
        chk("drop_no_ovr", 32'(overrun), 0);
`endif
        stat_clr = 1; step(); stat_clr = 0;
        chk("par_clr", 32'(par_err_cnt), 0);

        // Reset in the middle of a pending config and a non-empty FIFO.
        rx_busy = 1; cfg_req(6'd32, 1, 1);
        step(); cfg_wr = 0;
        data_valid = 1; P_DATA = 8'h11; step(); P_DATA = 8'h22; step(); data_valid = 0;
        chk("pre_rst_cnt", 32'(fifo_cnt), 2);
        RST = 0; #1;
        chk("mid_rst_fifo", 32'({rd_valid, fifo_cnt}), 0);
        chk("mid_rst_data", 32'(rd_data), 0);
        chk("mid_rst_cfg", 32'({prescale, PAR_EN, PAR_TYP, cfg_pend}), 32'({6'd8, 3'b000}));
        step(); RST = 1; rx_busy = 0;
        step(); step(); step();
        chk("post_rst_cfg", 32'({prescale, PAR_EN, PAR_TYP, cfg_pend}), 32'({6'd8, 3'b000}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
